// File: rtl/eth_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_test_pkg
// Description : Shared definitions for the Ethernet test frame generator:
//               FSM state encoding, PRBS-31 polynomial/seed and payload
//               mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_test_pkg;

   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_HDR     = 3'd1;
   localparam state_t ST_PAYLOAD = 3'd2;
   localparam state_t ST_GAP     = 3'd3;
   localparam state_t ST_DONE    = 3'd4;

   // x^31 + x^28 + 1: feedback taps on state bits 30 and 27
   localparam logic [30:0] PRBS_POLY = 31'h4800_0000;
   localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

   localparam logic MODE_COUNT = 1'b0;
   localparam logic MODE_PRBS  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/prbs31_gen.sv
`default_nettype none
// ============================================================================
// Module      : prbs31_gen
// Description : PRBS-31 (x^31+x^28+1) byte generator. Presents BYTES bytes
//               of sequence combinationally from the current state; each
//               byte is 8 consecutive sequence bits, first bit in the LSB,
//               bytes in ascending lane order.
// Ports       : clk, rst_n    - clock, async active-low reset (state -> 0)
//               load          - reseed state to PRBS_SEED
//               advance       - step state by 8*BYTES bits
//               data          - current 8*BYTES-bit word
// Revision    : 1.0 - initial release
// ============================================================================
module prbs31_gen
   import eth_test_pkg::*;
#(
   parameter int BYTES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               advance,
   output logic [8*BYTES-1:0] data
);

   logic [30:0] lfsr;
   logic [30:0] lfsr_next;

   // Unroll 8*BYTES Fibonacci steps; each new feedback bit is also the
   // emitted sequence bit.
   always_comb begin : p_step
      logic [30:0] s;
      logic        fb;
      s    = lfsr;
      fb   = 1'b0;
      data = '0;
      for (int i = 0; i < 8*BYTES; i++) begin
         fb      = ^(s & PRBS_POLY);
         data[i] = fb;
         s       = {s[29:0], fb};
      end
      lfsr_next = s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= '0;
      end else if (load) begin
         lfsr <= PRBS_SEED;
      end else if (advance) begin
         lfsr <= lfsr_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/eth_test_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : eth_test_frame_gen
// Description : Ethernet test frame source for eth_axis_tx. Emits a header
//               handshake followed by a payload stream of runtime-selected
//               length (counter or PRBS-31 pattern), with optional gap and
//               frame limit, plus frame/byte statistics.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               cfg_enable/length/gap/frame_limit/mode - runtime controls
//               m_eth_hdr_*                - header channel (constant fields)
//               m_eth_payload_axis_*       - AXI-stream payload channel
//               busy, done                 - status
//               frame_count, byte_count    - statistics (wrap, reset-only clear)
// Revision    : 1.0 - initial release
// ============================================================================
module eth_test_frame_gen
   import eth_test_pkg::*;
#(
   parameter int          DATA_WIDTH  = 8,
   parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int          KEEP_WIDTH  = (DATA_WIDTH / 8),
   parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_00,
   parameter logic [47:0] DST_MAC     = 48'h02_00_00_00_00_00,
   parameter logic [15:0] ETH_TYPE    = 16'h88B5,
   parameter int          LEN_WIDTH   = 16,
   parameter int          GAP_WIDTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_enable,
   input  logic [LEN_WIDTH-1:0]  cfg_length,
   input  logic [GAP_WIDTH-1:0]  cfg_gap,
   input  logic [31:0]           cfg_frame_limit,
   input  logic                  cfg_mode,
   output logic                  m_eth_hdr_valid,
   input  logic                  m_eth_hdr_ready,
   output logic [47:0]           m_eth_dest_mac,
   output logic [47:0]           m_eth_src_mac,
   output logic [15:0]           m_eth_type,
   output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
   output logic                  m_eth_payload_axis_tvalid,
   input  logic                  m_eth_payload_axis_tready,
   output logic                  m_eth_payload_axis_tlast,
   output logic                  m_eth_payload_axis_tuser,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           frame_count,
   output logic [47:0]           byte_count
);

   localparam logic [LEN_WIDTH:0] KW_LEN = (LEN_WIDTH+1)'(KEEP_WIDTH);

   state_t                  state;
   state_t                  state_next;

   // Bytes still to send, including the beat currently presented
   logic [LEN_WIDTH-1:0]    len_left;
   logic [GAP_WIDTH-1:0]    gap_lat;
   logic [GAP_WIDTH-1:0]    gap_cnt;
   logic                    mode_lat;
   // Counter-pattern value of lane 0 for the current beat
   logic [7:0]              lane_base;

   logic                    hdr_fire;
   logic                    beat_fire;
   logic                    last_beat;
   logic                    last_fire;
   logic                    hdr_entry;
   logic                    limit_hit;
   logic [KEEP_WIDTH-1:0]   keep_w;
   logic [DATA_WIDTH-1:0]   cnt_data;
   logic [DATA_WIDTH-1:0]   prbs_data;
   logic [47:0]             keep_pop;

   assign m_eth_dest_mac           = DST_MAC;
   assign m_eth_src_mac            = LOCAL_MAC;
   assign m_eth_type               = ETH_TYPE;
   assign m_eth_payload_axis_tuser = 1'b0;

   assign hdr_fire  = m_eth_hdr_valid && m_eth_hdr_ready;
   assign beat_fire = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;
   assign last_beat = ({1'b0, len_left} <= KW_LEN);
   assign last_fire = beat_fire && last_beat;
   // Covers re-entry straight from PAYLOAD when the gap is zero
   assign hdr_entry = (state_next == ST_HDR) && (state != ST_HDR);
   assign limit_hit = (cfg_frame_limit != 32'd0) &&
                      ((frame_count + 32'd1) == cfg_frame_limit);

   // ---------------------------------------------------------------- lanes
   for (genvar k = 0; k < KEEP_WIDTH; k++) begin : g_lane
      assign cnt_data[8*k +: 8] = lane_base + 8'(k);
   end

   if (KEEP_ENABLE) begin : g_keep_on
      // Lane k is valid while more than k bytes remain
      for (genvar k = 0; k < KEEP_WIDTH; k++) begin : g_keep_lane
         assign keep_w[k] = ({1'b0, len_left} > (LEN_WIDTH+1)'(k));
      end
   end else begin : g_keep_off
      assign keep_w = '1;
   end

   always_comb begin
      keep_pop = '0;
      for (int k = 0; k < KEEP_WIDTH; k++) begin
         keep_pop = keep_pop + 48'(m_eth_payload_axis_tkeep[k]);
      end
   end

   prbs31_gen #(
      .BYTES   (KEEP_WIDTH)
   ) u_prbs (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (hdr_entry),
      .advance (beat_fire),
      .data    (prbs_data)
   );

   // ----------------------------------------------------------- FSM: state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------ FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (cfg_enable) state_next = ST_HDR;
         end
         ST_HDR: begin
            if (hdr_fire) state_next = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (last_fire) begin
               if (limit_hit)              state_next = ST_DONE;
               else if (gap_lat != '0)     state_next = ST_GAP;
               else if (cfg_enable)        state_next = ST_HDR;
               else                        state_next = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_WIDTH'(1)) begin
               state_next = cfg_enable ? ST_HDR : ST_IDLE;
            end
         end
         ST_DONE: begin
            if (!cfg_enable) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // --------------------------------------------------------- FSM: outputs
   always_comb begin
      m_eth_hdr_valid           = (state == ST_HDR);
      m_eth_payload_axis_tvalid = (state == ST_PAYLOAD);
      m_eth_payload_axis_tlast  = (state == ST_PAYLOAD) && last_beat;
      m_eth_payload_axis_tkeep  = keep_w;
      m_eth_payload_axis_tdata  = (mode_lat == MODE_COUNT) ? cnt_data : prbs_data;
      busy                      = (state != ST_IDLE) && (state != ST_DONE);
      done                      = (state == ST_DONE);
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_left    <= '0;
         gap_lat     <= '0;
         gap_cnt     <= '0;
         mode_lat    <= MODE_COUNT;
         lane_base   <= '0;
         frame_count <= '0;
         byte_count  <= '0;
      end else begin
         if (hdr_entry) begin
            len_left  <= (cfg_length == '0) ? LEN_WIDTH'(1) : cfg_length;
            gap_lat   <= cfg_gap;
            mode_lat  <= cfg_mode;
            lane_base <= '0;
         end else if (beat_fire) begin
            len_left  <= len_left - KW_LEN[LEN_WIDTH-1:0];
            lane_base <= lane_base + 8'(KEEP_WIDTH);
         end

         if (last_fire) begin
            frame_count <= frame_count + 32'd1;
            gap_cnt     <= gap_lat;
         end else if (state == ST_GAP) begin
            gap_cnt     <= gap_cnt - GAP_WIDTH'(1);
         end

         if (beat_fire) begin
            byte_count <= byte_count + keep_pop;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_eth_test_frame_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_test_frame_gen
// Description : Self-checking bench for eth_test_frame_gen. An 8-bit
//               instance carries most scenarios; a 64-bit instance covers
//               partial tkeep on the last beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_test_frame_gen;

   localparam logic [47:0] MAC_SRC = 48'h02_11_22_33_44_55;
   localparam logic [47:0] MAC_DST = 48'h02_AA_BB_CC_DD_EE;
   localparam logic [15:0] ETYPE   = 16'h88B5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cfg_length;
   logic [15:0] cfg_gap;
   logic [31:0] cfg_limit;
   logic        cfg_mode;
   logic        en8, en64;
   logic        hr8, tr8, hr64, tr64;

   logic        hv8, tv8, tl8, tu8, busy8, done8;
   logic [47:0] dmac8, smac8;
   logic [15:0] type8;
   logic [7:0]  td8;
   logic [0:0]  tk8;
   logic [31:0] fc8;
   logic [47:0] bc8;

   logic        hv64, tv64, tl64, tu64, busy64, done64;
   logic [47:0] dmac64, smac64;
   logic [15:0] type64;
   logic [63:0] td64;
   logic [7:0]  tk64;
   logic [31:0] fc64;
   logic [47:0] bc64;

   int          checks = 0;
   int          errors = 0;
   int          hdr_fires = 0;
   logic [7:0]  prbs_ref [0:255];

   always #5 clk = ~clk;

   eth_test_frame_gen #(
      .DATA_WIDTH (8), .LOCAL_MAC (MAC_SRC), .DST_MAC (MAC_DST), .ETH_TYPE (ETYPE)
   ) dut8 (
      .clk (clk), .rst_n (rst_n), .cfg_enable (en8), .cfg_length (cfg_length),
      .cfg_gap (cfg_gap), .cfg_frame_limit (cfg_limit), .cfg_mode (cfg_mode),
      .m_eth_hdr_valid (hv8), .m_eth_hdr_ready (hr8), .m_eth_dest_mac (dmac8),
      .m_eth_src_mac (smac8), .m_eth_type (type8),
      .m_eth_payload_axis_tdata (td8), .m_eth_payload_axis_tkeep (tk8),
      .m_eth_payload_axis_tvalid (tv8), .m_eth_payload_axis_tready (tr8),
      .m_eth_payload_axis_tlast (tl8), .m_eth_payload_axis_tuser (tu8),
      .busy (busy8), .done (done8), .frame_count (fc8), .byte_count (bc8)
   );

   eth_test_frame_gen #(
      .DATA_WIDTH (64), .LOCAL_MAC (MAC_SRC), .DST_MAC (MAC_DST), .ETH_TYPE (ETYPE)
   ) dut64 (
      .clk (clk), .rst_n (rst_n), .cfg_enable (en64), .cfg_length (cfg_length),
      .cfg_gap (cfg_gap), .cfg_frame_limit (cfg_limit), .cfg_mode (cfg_mode),
      .m_eth_hdr_valid (hv64), .m_eth_hdr_ready (hr64), .m_eth_dest_mac (dmac64),
      .m_eth_src_mac (smac64), .m_eth_type (type64),
      .m_eth_payload_axis_tdata (td64), .m_eth_payload_axis_tkeep (tk64),
      .m_eth_payload_axis_tvalid (tv64), .m_eth_payload_axis_tready (tr64),
      .m_eth_payload_axis_tlast (tl64), .m_eth_payload_axis_tuser (tu64),
      .busy (busy64), .done (done64), .frame_count (fc64), .byte_count (bc64)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // PRBS-31 as a bit recurrence: x[n] = x[n-31] ^ x[n-28], history seeded
   // with 31 ones; output bits are x[31], x[32], ... packed LSB first.
   task automatic build_prbs();
      bit hist [0:31+2048-1];
      for (int i = 0; i < 31; i++) hist[i] = 1'b1;
      for (int n = 31; n < 31 + 2048; n++) hist[n] = hist[n-31] ^ hist[n-28];
      for (int b = 0; b < 256; b++)
         for (int i = 0; i < 8; i++) prbs_ref[b][i] = hist[31 + 8*b + i];
   endtask

   function automatic logic [7:0] exp_byte(input bit mode, input int idx);
      return mode ? prbs_ref[idx % 256] : 8'(idx % 256);
   endfunction

   task automatic do_reset();
      en8 = 1'b0;
      en64 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drives readies and checks the 8-bit instance cycle by cycle until
   // nframes tlast beats have been observed (fire pending at exit).
   task automatic run8(input int nframes, input int len, input int gap, input bit mode,
                       input bit rnd, input int stop_frame, input int budget);
      int         frames = 0;
      int         bidx = 0;
      int         gcnt = -1;
      int         cyc = 0;
      bit         stalled = 1'b0;
      logic [7:0] hd = '0;
      logic       hl = 1'b0;
      while (frames < nframes && cyc < budget) begin
         @(negedge clk);
         tr8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         hr8 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         cyc++;
         chk("hdr_pay_exclusive", 64'(hv8 & tv8), 64'd0);
         if (stalled) begin
            chk("stall_tvalid", 64'(tv8), 64'd1);
            chk("stall_tdata", 64'(td8), 64'(hd));
            chk("stall_tlast", 64'(tl8), 64'(hl));
         end
         if (gcnt >= 0) begin
            if (hv8) begin
               chk("gap_cycles", 64'(gcnt), 64'(gap));
               gcnt = -1;
            end else begin
               gcnt++;
            end
         end
         if (hv8 && hr8) hdr_fires++;
         if (tv8 && tr8) begin
            chk("tdata", 64'(td8), 64'(exp_byte(mode, bidx)));
            chk("tkeep", 64'(tk8), 64'd1);
            chk("tlast", 64'(tl8), 64'(bidx == len - 1));
            bidx++;
            if (stop_frame != 0 && frames == stop_frame - 1 && bidx == 2) en8 = 1'b0;
            if (tl8) begin
               frames++;
               bidx = 0;
               if (frames < nframes) gcnt = 0;
            end
         end
         stalled = tv8 && !tr8;
         hd = td8;
         hl = tl8;
      end
      chk("frames_seen", 64'(frames), 64'(nframes));
   endtask

   initial begin
      int         n;
      int         cyc;
      int         len;
      int         gap;
      int         lim;
      bit         mode;
      logic [63:0] bd [0:1];
      logic [7:0]  bk [0:1];
      logic        bl [0:1];

      rst_n = 1'b0;
      en8 = 1'b0; en64 = 1'b0;
      hr8 = 1'b1; tr8 = 1'b1; hr64 = 1'b1; tr64 = 1'b1;
      cfg_length = 16'd4; cfg_gap = 16'd0; cfg_limit = 32'd0; cfg_mode = 1'b0;
      build_prbs();

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_hdr_valid", 64'(hv8), 64'd0);
      chk("rst_tvalid", 64'(tv8), 64'd0);
      chk("rst_tlast", 64'(tl8), 64'd0);
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_frame_count", 64'(fc8), 64'd0);
      chk("rst_byte_count", 64'(bc8), 64'd0);
      chk("rst_tvalid64", 64'(tv64 | hv64 | busy64 | done64 | tl64), 64'd0);
      chk("const_dst", 64'(dmac8), 64'(MAC_DST));
      chk("const_src", 64'(smac64), 64'(MAC_SRC));
      chk("const_type", 64'({type8, type64}), 64'({ETYPE, ETYPE}));
      chk("const_dst64_src8", 64'(dmac64 ^ smac8), 64'(MAC_DST ^ MAC_SRC));
      chk("const_tuser", 64'({tu8, tu64}), 64'd0);
      rst_n = 1'b1;

      // 1: two 4-byte counter frames, back to back
      cfg_length = 16'd4; cfg_gap = 16'd0; cfg_limit = 32'd2; cfg_mode = 1'b0;
      hdr_fires = 0;
      en8 = 1'b1;
      run8(2, 4, 0, 1'b0, 1'b0, 0, 200);
      chk("t1_hdr_fires", 64'(hdr_fires), 64'd2);
      @(negedge clk); #1;
      chk("t1_done", 64'(done8), 64'd1);
      chk("t1_busy", 64'(busy8), 64'd0);
      chk("t1_frame_count", 64'(fc8), 64'd2);
      chk("t1_byte_count", 64'(bc8), 64'd8);
      repeat (3) begin
         @(negedge clk); #1;
         chk("t1_done_quiet", 64'({hv8, tv8, done8}), 64'b001);
      end
      en8 = 1'b0;
      @(negedge clk); #1;
      chk("t1_done_release", 64'(done8), 64'd0);
      chk("t1_counters_hold", 64'(fc8), 64'd2);

      // Length 0 behaves as length 1
      do_reset();
      cfg_length = 16'd0; cfg_limit = 32'd1;
      en8 = 1'b1;
      run8(1, 1, 0, 1'b0, 1'b0, 0, 100);
      @(negedge clk); #1;
      chk("len0_byte_count", 64'(bc8), 64'd1);
      chk("len0_done", 64'(done8), 64'd1);

      // 2: 64-bit instance, 13 bytes -> partial last beat
      do_reset();
      cfg_length = 16'd13; cfg_gap = 16'd0; cfg_limit = 32'd1; cfg_mode = 1'b0;
      en64 = 1'b1;
      n = 0; cyc = 0;
      while (n < 2 && cyc < 100) begin
         @(negedge clk); #1;
         cyc++;
         if (tv64 && tr64) begin
            bd[n] = td64; bk[n] = tk64; bl[n] = tl64;
            n++;
         end
      end
      chk("t2_beats", 64'(n), 64'd2);
      chk("t2_b0_data", bd[0], 64'h0706050403020100);
      chk("t2_b0_keep", 64'(bk[0]), 64'hFF);
      chk("t2_b0_last", 64'(bl[0]), 64'd0);
      chk("t2_b1_data", bd[1], 64'h0F0E0D0C0B0A0908);
      chk("t2_b1_keep", 64'(bk[1]), 64'h1F);
      chk("t2_b1_last", 64'(bl[1]), 64'd1);
      @(negedge clk); #1;
      chk("t2_byte_count", 64'(bc64), 64'd13);
      chk("t2_frame_count", 64'(fc64), 64'd1);
      chk("t2_done", 64'(done64), 64'd1);
      en64 = 1'b0;

      // 3: 64-byte frames, gap 5, random backpressure
      do_reset();
      cfg_length = 16'd64; cfg_gap = 16'd5; cfg_limit = 32'd3; cfg_mode = 1'b0;
      en8 = 1'b1;
      run8(3, 64, 5, 1'b0, 1'b1, 0, 5000);
      @(negedge clk); #1;
      chk("t3_frame_count", 64'(fc8), 64'd3);
      chk("t3_byte_count", 64'(bc8), 64'd192);
      chk("t3_done", 64'(done8), 64'd1);
      tr8 = 1'b1; hr8 = 1'b1;

      // 4: graceful stop mid-frame 2, unlimited
      do_reset();
      cfg_length = 16'd8; cfg_gap = 16'd0; cfg_limit = 32'd0;
      en8 = 1'b1;
      run8(2, 8, 0, 1'b0, 1'b0, 2, 500);
      @(negedge clk); #1;
      chk("t4_busy", 64'(busy8), 64'd0);
      chk("t4_done", 64'(done8), 64'd0);
      chk("t4_frame_count", 64'(fc8), 64'd2);
      chk("t4_byte_count", 64'(bc8), 64'd16);
      repeat (3) begin
         @(negedge clk); #1;
         chk("t4_idle_quiet", 64'({hv8, tv8}), 64'd0);
      end

      // 5: PRBS mode, each frame restarts from the seed
      do_reset();
      cfg_length = 16'd8; cfg_gap = 16'd0; cfg_limit = 32'd2; cfg_mode = 1'b1;
      en8 = 1'b1;
      run8(2, 8, 0, 1'b1, 1'b0, 0, 200);
      @(negedge clk); #1;
      chk("t5_done", 64'(done8), 64'd1);
      chk("t5_byte_count", 64'(bc8), 64'd16);

      // Randomized configurations against the reference model
      for (int it = 0; it < 6; it++) begin
         do_reset();
         len  = int'($urandom_range(1, 40));
         gap  = int'($urandom_range(0, 3));
         lim  = int'($urandom_range(1, 3));
         mode = 1'($urandom_range(0, 1));
         cfg_length = 16'(len); cfg_gap = 16'(gap); cfg_limit = 32'(lim); cfg_mode = mode;
         en8 = 1'b1;
         run8(lim, len, gap, mode, 1'b1, 0, 3000);
         @(negedge clk); #1;
         chk("rnd_frame_count", 64'(fc8), 64'(lim));
         chk("rnd_byte_count", 64'(bc8), 64'(lim * len));
         chk("rnd_done", 64'(done8), 64'd1);
      end
      tr8 = 1'b1; hr8 = 1'b1;

      // 6: asynchronous reset mid-payload
      do_reset();
      cfg_length = 16'd4; cfg_gap = 16'd0; cfg_limit = 32'd0; cfg_mode = 1'b0;
      en8 = 1'b1;
      run8(1, 4, 0, 1'b0, 1'b0, 0, 100);
      n = 0; cyc = 0;
      while (n < 2 && cyc < 100) begin
         @(negedge clk); #1;
         cyc++;
         if (tv8 && tr8) n++;
      end
      chk("t6_pre_beats", 64'(n), 64'd2);
      @(posedge clk); #3;
      chk("t6_pre_frame_count", 64'(fc8), 64'd1);
      chk("t6_pre_tvalid", 64'(tv8), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valids", 64'({hv8, tv8, tl8}), 64'd0);
      chk("t6_rst_busy", 64'(busy8), 64'd0);
      chk("t6_rst_frame_count", 64'(fc8), 64'd0);
      chk("t6_rst_byte_count", 64'(bc8), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run8(1, 4, 0, 1'b0, 1'b0, 0, 100);
      en8 = 1'b0;
      repeat (10) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
